// File: rtl/status_reg_bank_pkg.sv
// ============================================================================
// Module : status_pkg
// Brief  : Shared constants and types for the banked NZCV status register.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package status_pkg;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int NUM_BANKS_DEF = 4;
  localparam int USER          = 0;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

endpackage

`default_nettype wire

// File: rtl/status_reg_bank_if.sv
// ============================================================================
// Module : status_reg_bank_if
// Brief  : Flag update, exception and condition-check bus of status_reg_bank.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface status_reg_bank_if #(
  parameter int FLAG_W    = 4,
  parameter int NUM_BANKS = status_pkg::NUM_BANKS_DEF
) ();

  localparam int BANK_W = $clog2(NUM_BANKS);

  logic              s;
  logic [FLAG_W-1:0] stat_bits;
  logic [FLAG_W-1:0] wr_mask;
  logic              exc_entry;
  logic [BANK_W-1:0] exc_bank;
  logic              exc_return;
  logic [3:0]        cond;

  logic [FLAG_W-1:0]    stat_bits_reg;
  logic                 carry;
  logic                 cond_pass;
  logic [BANK_W-1:0]    cur_bank;
  logic [NUM_BANKS-1:0] saved_valid;
  logic                 exc_err;

  modport master (
    output s, stat_bits, wr_mask, exc_entry, exc_bank, exc_return, cond,
    input  stat_bits_reg, carry, cond_pass, cur_bank, saved_valid, exc_err
  );

  modport slave (
    input  s, stat_bits, wr_mask, exc_entry, exc_bank, exc_return, cond,
    output stat_bits_reg, carry, cond_pass, cur_bank, saved_valid, exc_err
  );

endinterface

`default_nettype wire

// File: rtl/status_reg_bank_cond_eval.sv
// ============================================================================
// Module : cond_eval
// Brief  : Combinational ARM condition-field check against NZCV flags.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cond_eval
  import status_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [3:0] cond,
  output logic       pass
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = flags[FLAG_N];
  assign w_z = flags[FLAG_Z];
  assign w_c = flags[FLAG_C];
  assign w_v = flags[FLAG_V];

  always_comb begin
    pass = 1'b1;
    case (cond_e'(cond))
      COND_EQ: pass = w_z;
      COND_NE: pass = !w_z;
      COND_CS: pass = w_c;
      COND_CC: pass = !w_c;
      COND_MI: pass = w_n;
      COND_PL: pass = !w_n;
      COND_VS: pass = w_v;
      COND_VC: pass = !w_v;
      COND_HI: pass = w_c && !w_z;
      COND_LS: pass = !w_c || w_z;
      COND_GE: pass = (w_n == w_v);
      COND_LT: pass = (w_n != w_v);
      COND_GT: pass = !w_z && (w_n == w_v);
      COND_LE: pass = w_z || (w_n != w_v);
      default: pass = 1'b1;  // AL, and NV reserved as AL
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/status_reg_bank.sv
// ============================================================================
// Module : status_reg_bank
// Brief  : Banked status register with masked update, save/restore and cond check.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module status_reg_bank
  import status_pkg::*;
#(
  parameter int FLAG_W    = 4,
  parameter int NUM_BANKS = NUM_BANKS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  status_reg_bank_if.slave   bus
);

  localparam int BANK_W = $clog2(NUM_BANKS);

  logic [FLAG_W-1:0]    r_flags;
  logic [BANK_W-1:0]    r_cur_bank;
  logic [NUM_BANKS-1:0] r_valid;
  logic                 r_err;
  logic [FLAG_W-1:0]    r_saved    [NUM_BANKS];
  logic [BANK_W-1:0]    r_ret_bank [NUM_BANKS];

  logic [FLAG_W-1:0] w_merged;
  logic              w_entry_ok;
  logic              w_return_ok;
  logic              w_err;

  assign w_merged = bus.s ? ((r_flags & ~bus.wr_mask) | (bus.stat_bits & bus.wr_mask))
                          : r_flags;

  assign w_entry_ok  = bus.exc_entry && (bus.exc_bank != BANK_W'(USER)) &&
                       (32'(bus.exc_bank) < NUM_BANKS);
  // Entry has priority, so a simultaneous return is dropped silently.
  assign w_return_ok = !bus.exc_entry && bus.exc_return &&
                       (r_cur_bank != BANK_W'(USER)) && r_valid[r_cur_bank];
  assign w_err       = bus.exc_entry ? !w_entry_ok : (bus.exc_return && !w_return_ok);

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      r_flags    <= '0;
      r_cur_bank <= '0;
      r_valid    <= '0;
      r_err      <= 1'b0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        r_saved[b]    <= '0;
        r_ret_bank[b] <= '0;
      end
    end else begin
      r_err <= w_err;
      if (w_entry_ok) begin
        r_saved[bus.exc_bank]    <= w_merged;
        r_ret_bank[bus.exc_bank] <= r_cur_bank;
        r_valid[bus.exc_bank]    <= 1'b1;
        r_cur_bank               <= bus.exc_bank;
        r_flags                  <= w_merged;
      end else if (w_return_ok) begin
        r_flags             <= r_saved[r_cur_bank];
        r_cur_bank          <= r_ret_bank[r_cur_bank];
        r_valid[r_cur_bank] <= 1'b0;
      end else if (!bus.exc_entry && !bus.exc_return) begin
        r_flags <= w_merged;
      end
    end
  end

  assign bus.stat_bits_reg = r_flags;
  assign bus.carry         = r_flags[FLAG_C];
  assign bus.cur_bank      = r_cur_bank;
  assign bus.saved_valid   = r_valid;
  assign bus.exc_err       = r_err;

  cond_eval u_cond_eval (
    .flags (r_flags[3:0]),
    .cond  (bus.cond),
    .pass  (bus.cond_pass)
  );

endmodule

`default_nettype wire
